// File: rtl/data_island_packet_serializer_if.sv
// ---------------------------------------------------------------------------
// data_island_packet_serializer_if
// Groups the packet-in handshake and the serialized data-island word stream
// of the data island packet serializer.
//   in_valid    : source holds a packet on header/sub
//   in_ready    : serializer accepts a packet this cycle
//   header      : HB2,HB1,HB0 ([7:0]=HB0)
//   sub         : four 56-bit subpackets, sub[i][7:0] = byte 0 of subpacket i
//   out_valid   : packet_data valid this cycle
//   out_first   : word 0 of a packet
//   out_last    : word 31 of a packet
//   packet_data : [0]=ch0 bit2, [4:1]=ch1 bits, [8:5]=ch2 bits
// master = packet source / TERC4 side, slave = serializer.
// ---------------------------------------------------------------------------
interface data_island_packet_serializer_if;
    logic             in_valid;
    logic             in_ready;
    logic [23:0]      header;
    logic [3:0][55:0] sub;
    logic             out_valid;
    logic             out_first;
    logic             out_last;
    logic [8:0]       packet_data;

    modport master (
        output in_valid, header, sub,
        input  in_ready, out_valid, out_first, out_last, packet_data
    );

    modport slave (
        input  in_valid, header, sub,
        output in_ready, out_valid, out_first, out_last, packet_data
    );
endinterface

// File: rtl/data_island_packet_serializer.sv
// ---------------------------------------------------------------------------
// data_island_packet_serializer
// Latches one packet (24-bit header + four 56-bit subpackets), appends the
// BCH(32,24) header parity and BCH(64,56) subpacket parities, and emits the
// packet as 32 consecutive 9-bit data-island words, LSB first. Parity is
// accumulated serially as the data bits are emitted.
// Ports:
//   clk_pixel : pixel clock
//   reset_n   : synchronous reset, active low
//   bus       : slave modport of data_island_packet_serializer_if
// ---------------------------------------------------------------------------
module data_island_packet_serializer (
    input  logic                               clk_pixel,
    input  logic                               reset_n,
    data_island_packet_serializer_if.slave     bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // One LFSR step of G(x)=1+x^6+x^7+x^8 for data bit b.
    function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
        logic [7:0] fb;
        fb       = (e[0] ^ b) ? 8'h83 : 8'h00;
        ecc_step = {1'b0, e[7:1]} ^ fb;
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [4:0]       k_r;
    logic [4:0]       k_next_s;
    logic [4:0]       j_s;
    logic [7:0]       hecc_r;
    logic [7:0]       hecc_next_s;
    logic [3:0][7:0]  secc_r;
    logic [3:0][7:0]  secc_next_s;
    logic [23:0]      hdr_sh_r;
    logic [23:0]      hdr_sh_next_s;
    logic [3:0][55:0] sub_sh_r;
    logic [3:0][55:0] sub_sh_next_s;
    logic             accept_s;
    logic             do_load_s;
    logic             do_adv_s;
    logic             in_ready_next_s;
    logic             valid_next_s;
    logic             first_next_s;
    logic             last_next_s;
    logic [8:0]       data_next_s;

    // Next-state logic: load on accept, otherwise walk the 32 words.
    always_comb begin
        accept_s     = bus.in_valid & bus.in_ready;
        do_load_s    = 1'b0;
        do_adv_s     = 1'b0;
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    do_load_s    = 1'b1;
                    state_next_s = SEND;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SEND: begin
                if (k_r != 5'd31) begin
                    do_adv_s     = 1'b1;
                    state_next_s = SEND;
                end else if (accept_s) begin
                    // Back-to-back: word 0 of the next packet follows word 31.
                    do_load_s    = 1'b1;
                    state_next_s = SEND;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Datapath: next word, parity accumulation and shadow shift registers.
    always_comb begin
        k_next_s      = k_r;
        j_s           = k_r + 5'd1;
        hecc_next_s   = hecc_r;
        secc_next_s   = secc_r;
        hdr_sh_next_s = hdr_sh_r;
        sub_sh_next_s = sub_sh_r;
        valid_next_s  = 1'b0;
        first_next_s  = 1'b0;
        last_next_s   = 1'b0;
        data_next_s   = 9'd0;

        if (do_load_s) begin
            // Word 0 comes straight from the inputs; the rest is shadowed
            // already shifted so bit 0 is always the next bit to send.
            k_next_s       = 5'd0;
            valid_next_s   = 1'b1;
            first_next_s   = 1'b1;
            data_next_s[0] = bus.header[0];
            hecc_next_s    = ecc_step(8'h00, bus.header[0]);
            hdr_sh_next_s  = {1'b0, bus.header[23:1]};
            for (int i = 0; i < 4; i++) begin
                data_next_s[1+i] = bus.sub[i][0];
                data_next_s[5+i] = bus.sub[i][1];
                secc_next_s[i]   = ecc_step(ecc_step(8'h00, bus.sub[i][0]), bus.sub[i][1]);
                sub_sh_next_s[i] = {2'b00, bus.sub[i][55:2]};
            end
        end else if (do_adv_s) begin
            k_next_s     = j_s;
            valid_next_s = 1'b1;
            last_next_s  = (j_s == 5'd31);

            if (j_s < 5'd24) begin
                data_next_s[0] = hdr_sh_r[0];
                hecc_next_s    = ecc_step(hecc_r, hdr_sh_r[0]);
                hdr_sh_next_s  = {1'b0, hdr_sh_r[23:1]};
            end else begin
                // Words 24..31: parity byte, frozen, bit index = j-24.
                data_next_s[0] = hecc_r[j_s[2:0]];
            end

            for (int i = 0; i < 4; i++) begin
                if (j_s < 5'd28) begin
                    data_next_s[1+i] = sub_sh_r[i][0];
                    data_next_s[5+i] = sub_sh_r[i][1];
                    secc_next_s[i]   = ecc_step(ecc_step(secc_r[i], sub_sh_r[i][0]), sub_sh_r[i][1]);
                    sub_sh_next_s[i] = {2'b00, sub_sh_r[i][55:2]};
                end else begin
                    // Words 28..31 carry parity bits 2(j-28) and 2(j-28)+1.
                    data_next_s[1+i] = secc_r[i][{j_s[1:0], 1'b0}];
                    data_next_s[5+i] = secc_r[i][{j_s[1:0], 1'b1}];
                end
            end
        end else begin
            // Idle: outputs quiet, counter and parity hold.
            k_next_s = k_r;
        end

        if (state_next_s == IDLE) begin
            in_ready_next_s = 1'b1;
        end else if (k_next_s == 5'd31) begin
            in_ready_next_s = 1'b1;
        end else begin
            in_ready_next_s = 1'b0;
        end
    end

    // State, datapath and registered outputs; reset aborts any packet.
    always_ff @(posedge clk_pixel) begin
        if (!reset_n) begin
            state_r         <= IDLE;
            k_r             <= 5'd0;
            hecc_r          <= 8'h00;
            secc_r          <= '0;
            hdr_sh_r        <= 24'd0;
            sub_sh_r        <= '0;
            bus.in_ready    <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.out_first   <= 1'b0;
            bus.out_last    <= 1'b0;
            bus.packet_data <= 9'd0;
        end else begin
            state_r         <= state_next_s;
            k_r             <= k_next_s;
            hecc_r          <= hecc_next_s;
            secc_r          <= secc_next_s;
            hdr_sh_r        <= hdr_sh_next_s;
            sub_sh_r        <= sub_sh_next_s;
            bus.in_ready    <= in_ready_next_s;
            bus.out_valid   <= valid_next_s;
            bus.out_first   <= first_next_s;
            bus.out_last    <= last_next_s;
            bus.packet_data <= data_next_s;
        end
    end

endmodule

// File: tb/tb_data_island_packet_serializer.sv
// ---------------------------------------------------------------------------
// tb_data_island_packet_serializer
// Directed bench for data_island_packet_serializer: reset behaviour, zero
// packet, single header bit (hand-computed parity 8'h4A), AVI-like packet
// against a bit-serial parity model, back-to-back packets and a mid-packet
// reset.
// ---------------------------------------------------------------------------
module tb_data_island_packet_serializer;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    logic [8:0] exp_w [3][32];
    logic [8:0] obs_w [32];
    logic [8:0] avi_w [32];

    data_island_packet_serializer_if bus ();

    data_island_packet_serializer dut (
        .clk_pixel (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_ecc(input logic [63:0] bits, input int n);
        logic [7:0] e;
        logic       fb;
        e = 8'h00;
        for (int i = 0; i < n; i++) begin
            fb = e[0] ^ bits[i];
            e  = e >> 1;
            if (fb) e = e ^ 8'h83;
        end
        return e;
    endfunction

    task automatic build_words(input logic [23:0] h, input logic [3:0][55:0] s, input int idx);
        logic [31:0]      hw;
        logic [3:0][63:0] sw;
        logic [8:0]       w;
        hw = {model_ecc({40'd0, h}, 24), h};
        for (int i = 0; i < 4; i++) sw[i] = {model_ecc({8'd0, s[i]}, 56), s[i]};
        for (int k = 0; k < 32; k++) begin
            w[0] = hw[k];
            for (int i = 0; i < 4; i++) begin
                w[1+i] = sw[i][2*k];
                w[5+i] = sw[i][2*k+1];
            end
            exp_w[idx][k] = w;
        end
    endtask

    // Expected {valid, first, last, data} for word k.
    function automatic logic [11:0] exp_word(input int idx, input int k);
        return {1'b1, (k == 0), (k == 31), exp_w[idx][k]};
    endfunction

    function automatic logic [11:0] dut_word();
        return {bus.out_valid, bus.out_first, bus.out_last, bus.packet_data};
    endfunction

    // Called at a negedge with the serializer idle; sends one packet and
    // checks all 32 words plus the return to idle.
    task automatic run_packet(input logic [23:0] h, input logic [3:0][55:0] s, input string tag);
        build_words(h, s, 0);
        check({tag, " ready_before"}, {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid = 1'b1;
        bus.header   = h;
        bus.sub      = s;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.header   = ~h;
        bus.sub      = ~s;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            obs_w[k] = bus.packet_data;
            check($sformatf("%s word%0d", tag, k), {52'd0, dut_word()}, {52'd0, exp_word(0, k)});
        end
        @(negedge clk);
        check({tag, " idle_after"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
    endtask

    logic [3:0][55:0] s_zero;
    logic [3:0][55:0] s_avi;
    logic [3:0][55:0] s_tmp;
    logic [7:0]       par;
    logic [23:0]      b2b_h [3];

    initial begin
        checks       = 0;
        failures     = 0;
        s_zero       = '0;
        reset_n      = 1'b0;
        bus.in_valid = 1'b1;
        bus.header   = 24'h123456;
        bus.sub      = '0;

        // 1. Reset held with in_valid high.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("reset cyc%0d", c),
                  {52'd0, bus.out_valid, bus.in_ready, 1'b0, bus.packet_data}, 64'd0);
        end
        reset_n      = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {62'd0, bus.in_ready, bus.out_valid}, 64'd2);

        // 2. All-zero packet.
        run_packet(24'h000000, s_zero, "zero");

        // 3. Single header bit: parity byte 8'h4A in bit 0 of words 24..31.
        run_packet(24'h000001, s_zero, "hbit");
        for (int k = 0; k < 8; k++) par[k] = obs_w[24+k][0];
        check("hbit_parity", {56'd0, par}, 64'h4A);
        check("hbit_first", {63'd0, obs_w[0][0]}, 64'd1);

        // 4. AVI-like packet, then the same with sub[3] bit 0 flipped.
        s_avi    = '0;
        s_avi[0] = 56'h0000001028105C;
        run_packet(24'h0D0282, s_avi, "avi");
        for (int k = 0; k < 32; k++) avi_w[k] = obs_w[k];
        s_tmp       = s_avi;
        s_tmp[3][0] = 1'b1;
        run_packet(24'h0D0282, s_tmp, "avi_s3");
        check("avi_diff_w0", {55'd0, avi_w[0] ^ obs_w[0]}, 64'h010);
        for (int k = 1; k < 32; k++) begin
            check($sformatf("avi_diff_w%0d", k),
                  {55'd0, (avi_w[k] ^ obs_w[k]) & 9'h0EF}, 64'd0);
        end

        // 5. Back-to-back: three packets with in_valid held high.
        b2b_h[0] = 24'hA5C301;
        b2b_h[1] = 24'h0F0F0F;
        b2b_h[2] = 24'h800002;
        for (int p = 0; p < 3; p++) begin
            s_tmp    = s_avi;
            s_tmp[1] = {8'(p), 48'hDEAD_BEEF_0123};
            build_words(b2b_h[p], s_tmp, p);
        end
        bus.in_valid = 1'b1;
        bus.header   = b2b_h[0];
        bus.sub      = s_avi;
        bus.sub[1]   = {8'd0, 48'hDEAD_BEEF_0123};
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 32; k++) begin
                @(negedge clk);
                check($sformatf("b2b p%0d word%0d", p, k),
                      {52'd0, dut_word()}, {52'd0, exp_word(p, k)});
                check($sformatf("b2b p%0d ready%0d", p, k),
                      {63'd0, bus.in_ready}, {63'd0, (k == 31)});
                if (k == 0 && p < 2) begin
                    // Present the next packet early; must not be taken before word 31.
                    bus.header = b2b_h[p+1];
                    bus.sub[1] = {8'(p + 1), 48'hDEAD_BEEF_0123};
                end
                if (k == 31 && p == 2) bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_end", {62'd0, bus.out_valid, bus.in_ready}, 64'd1);

        // 6. Reset at word 10, then a fresh packet.
        build_words(24'hFFFFFF, s_avi, 0);
        bus.in_valid = 1'b1;
        bus.header   = 24'hFFFFFF;
        bus.sub      = s_avi;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 11; k++) @(negedge clk);
        check("abort_word10", {52'd0, dut_word()}, {52'd0, exp_word(0, 10)});
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_out", {52'd0, dut_word()}, 64'd0);
        check("abort_ready", {63'd0, bus.in_ready}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_quiet", {52'd0, dut_word()}, 64'd0);
        run_packet(24'h0D0282, s_avi, "post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
